// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM state encoding
// and the all-bytes-enabled mask used for word reads.
package dmem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/dmem_bridge_if.sv
// Valid/ready request channel plus single-beat response channel of the
// variable-latency data bus. The bridge is the master, memory the slave.
interface dmem_bridge_if;

    logic        Bus_ReqValid;
    logic        Bus_ReqReady;
    logic [29:0] Bus_Addr;
    logic        Bus_Write;
    logic [3:0]  Bus_BE;
    logic [31:0] Bus_WData;
    logic        Bus_RespValid;
    logic [31:0] Bus_RData;
    logic        Bus_Error;

    modport master (
        output Bus_ReqValid, Bus_Addr, Bus_Write, Bus_BE, Bus_WData,
        input  Bus_ReqReady, Bus_RespValid, Bus_RData, Bus_Error
    );

    modport slave (
        input  Bus_ReqValid, Bus_Addr, Bus_Write, Bus_BE, Bus_WData,
        output Bus_ReqReady, Bus_RespValid, Bus_RData, Bus_Error
    );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Saturating response-wait counter. hit flags the last allowed wait cycle;
// a TIMEOUT of 0 keeps hit low forever.
module dmem_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Count wait cycles; clear wins over enable, and the count sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (TIMEOUT != 0) && (cnt == HIT_VAL);

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the memory controller's level-held read/write strobes onto one
// valid/ready bus transaction, returning a one-cycle DataMem_Ready pulse.
// A wait-for-response timeout completes the access with BusErr set.
module dmem_bridge
    import dmem_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] MWriteData,
    input  logic [3:0]  WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] MReadData,
    output logic        DataMem_Ready,
    output logic        BusErr,
    output logic        Busy,
    dmem_bridge_if.master bus
);

    state_e      state_q, state_d;
    logic        launch, accept, resp_take, to_hit, ctr_en, hit;
    logic [29:0] addr_q;
    logic [31:0] wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        write_q, err_q;
    logic        unused_addr_lo;

    // Word-aligned bus: the byte offset is carried by the byte enables instead.
    assign unused_addr_lo = ^Address[1:0];

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; responses outside WAIT are never looked at.
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        accept    = 1'b0;
        resp_take = 1'b0;
        to_hit    = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ReadEnable || (WriteEnable != 4'b0000)) begin
                    launch  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.Bus_ReqReady) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.Bus_RespValid) begin
                    resp_take = 1'b1;
                    state_d   = RESP;
                end else if (hit) begin
                    to_hit  = 1'b1;
                    state_d = RESP;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            RESP: begin
                // Strobes are still high here; going straight to IDLE avoids a relaunch.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture at launch and response/error capture on completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (launch) begin
                addr_q  <= Address[31:2];
                wdata_q <= MWriteData;
                write_q <= |WriteEnable;
                be_q    <= (|WriteEnable) ? WriteEnable : BE_ALL;
            end
            if (resp_take) begin
                err_q <= bus.Bus_Error;
                if (!write_q) rdata_q <= bus.Bus_Error ? 32'h0 : bus.Bus_RData;
            end else if (to_hit) begin
                err_q <= 1'b1;
                if (!write_q) rdata_q <= 32'h0;
            end
        end
    end

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .en    (ctr_en),
        .hit   (hit)
    );

    assign bus.Bus_ReqValid = (state_q == REQ);
    assign bus.Bus_Addr     = addr_q;
    assign bus.Bus_Write    = write_q;
    assign bus.Bus_BE       = be_q;
    assign bus.Bus_WData    = wdata_q;

    assign MReadData     = rdata_q;
    assign DataMem_Ready = (state_q == RESP);
    assign BusErr        = (state_q == RESP) && err_q;
    assign Busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: instance a uses TIMEOUT=4, instance b
// uses TIMEOUT=2 for the response/timeout collision case.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] a_Address = '0, a_MWriteData = '0;
    logic [3:0]  a_WriteEnable = '0;
    logic        a_ReadEnable = 1'b0;
    logic [31:0] a_MReadData;
    logic        a_Ready, a_BusErr, a_Busy;

    logic [31:0] b_Address = '0;
    logic        b_ReadEnable = 1'b0;
    logic [31:0] b_MReadData;
    logic        b_Ready, b_BusErr, b_Busy;

    dmem_bridge_if a_bus();
    dmem_bridge_if b_bus();

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(4), .CNT_W(8)) dut_a (
        .clock(clk), .reset(rst_n),
        .Address(a_Address), .MWriteData(a_MWriteData),
        .WriteEnable(a_WriteEnable), .ReadEnable(a_ReadEnable),
        .MReadData(a_MReadData), .DataMem_Ready(a_Ready),
        .BusErr(a_BusErr), .Busy(a_Busy), .bus(a_bus.master)
    );

    dmem_bridge #(.TIMEOUT(2), .CNT_W(2)) dut_b (
        .clock(clk), .reset(rst_n),
        .Address(b_Address), .MWriteData(32'h0),
        .WriteEnable(4'b0000), .ReadEnable(b_ReadEnable),
        .MReadData(b_MReadData), .DataMem_Ready(b_Ready),
        .BusErr(b_BusErr), .Busy(b_Busy), .bus(b_bus.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read on instance a: ready at once, response in cycle 2, ready pulse in cycle 3.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata,
                           input logic err, input logic [31:0] exp_rd, input logic exp_err);
        a_Address = addr;
        a_ReadEnable = 1'b1;
        a_bus.Bus_ReqReady = 1'b1;
        tick();
        tick();
        a_bus.Bus_RespValid = 1'b1;
        a_bus.Bus_RData = rdata;
        a_bus.Bus_Error = err;
        tick();
        a_bus.Bus_RespValid = 1'b0;
        a_bus.Bus_Error = 1'b0;
        chk("rd_ready", {31'h0, a_Ready}, 32'd1);
        chk("rd_data", a_MReadData, exp_rd);
        chk("rd_err", {31'h0, a_BusErr}, {31'h0, exp_err});
        tick();
        a_ReadEnable = 1'b0;
    endtask

    initial begin
        a_bus.Bus_ReqReady = 1'b0;
        a_bus.Bus_RespValid = 1'b0;
        a_bus.Bus_RData = '0;
        a_bus.Bus_Error = 1'b0;
        b_bus.Bus_ReqReady = 1'b1;
        b_bus.Bus_RespValid = 1'b0;
        b_bus.Bus_RData = '0;
        b_bus.Bus_Error = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_busy", {31'h0, a_Busy}, 32'd0);
        chk("rst_ready", {31'h0, a_Ready}, 32'd0);
        chk("rst_rdata", a_MReadData, 32'h0);
        chk("rst_reqvalid", {31'h0, a_bus.Bus_ReqValid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: read, zero-wait slave
        a_Address = 32'h0000_1004;
        a_ReadEnable = 1'b1;
        a_bus.Bus_ReqReady = 1'b1;
        tick();
        chk("t1_reqvalid", {31'h0, a_bus.Bus_ReqValid}, 32'd1);
        chk("t1_addr", {2'b0, a_bus.Bus_Addr}, 32'h401);
        chk("t1_be", {28'h0, a_bus.Bus_BE}, 32'hF);
        chk("t1_write", {31'h0, a_bus.Bus_Write}, 32'd0);
        tick();
        chk("t1_reqvalid_drop", {31'h0, a_bus.Bus_ReqValid}, 32'd0);
        chk("t1_early_ready", {31'h0, a_Ready}, 32'd0);
        a_bus.Bus_RespValid = 1'b1;
        a_bus.Bus_RData = 32'hDEAD_BEEF;
        tick();
        a_bus.Bus_RespValid = 1'b0;
        chk("t1_ready", {31'h0, a_Ready}, 32'd1);
        chk("t1_rdata", a_MReadData, 32'hDEAD_BEEF);
        chk("t1_buserr", {31'h0, a_BusErr}, 32'd0);
        tick();
        chk("t1_no_relaunch", {31'h0, a_bus.Bus_ReqValid}, 32'd0);
        chk("t1_ready_once", {31'h0, a_Ready}, 32'd0);
        chk("t1_idle", {31'h0, a_Busy}, 32'd0);
        a_ReadEnable = 1'b0;
        tick();

        // 2: byte write with backpressure; read asserted too, write must win
        a_Address = 32'h0000_2008;
        a_WriteEnable = 4'b0100;
        a_ReadEnable = 1'b1;
        a_MWriteData = 32'h00AB_0000;
        a_bus.Bus_ReqReady = 1'b0;
        tick();
        a_WriteEnable = 4'b0000;
        a_ReadEnable = 1'b0;
        a_Address = 32'hFFFF_FFFC;
        a_MWriteData = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) a_bus.Bus_ReqReady = 1'b1;
            chk("t2_reqvalid", {31'h0, a_bus.Bus_ReqValid}, 32'd1);
            chk("t2_addr", {2'b0, a_bus.Bus_Addr}, 32'h802);
            chk("t2_be", {28'h0, a_bus.Bus_BE}, 32'h4);
            chk("t2_write", {31'h0, a_bus.Bus_Write}, 32'd1);
            chk("t2_wdata", a_bus.Bus_WData, 32'h00AB_0000);
            tick();
        end
        chk("t2_reqvalid_drop", {31'h0, a_bus.Bus_ReqValid}, 32'd0);
        a_bus.Bus_RespValid = 1'b1;
        a_bus.Bus_RData = 32'hFFFF_FFFF;
        tick();
        a_bus.Bus_RespValid = 1'b0;
        chk("t2_ready", {31'h0, a_Ready}, 32'd1);
        chk("t2_buserr", {31'h0, a_BusErr}, 32'd0);
        chk("t2_rdata_kept", a_MReadData, 32'hDEAD_BEEF);
        tick();

        // 3: timeout (TIMEOUT=4), then a late response in IDLE
        a_Address = 32'h0000_3000;
        a_ReadEnable = 1'b1;
        tick();
        tick();
        a_ReadEnable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_early_ready", {31'h0, a_Ready}, 32'd0);
            tick();
        end
        chk("t3_ready", {31'h0, a_Ready}, 32'd1);
        chk("t3_buserr", {31'h0, a_BusErr}, 32'd1);
        chk("t3_rdata", a_MReadData, 32'h0);
        tick();
        a_bus.Bus_RespValid = 1'b1;
        a_bus.Bus_RData = 32'h1234_5678;
        tick();
        a_bus.Bus_RespValid = 1'b0;
        chk("t3_late_ready", {31'h0, a_Ready}, 32'd0);
        chk("t3_late_busy", {31'h0, a_Busy}, 32'd0);
        chk("t3_late_rdata", a_MReadData, 32'h0);
        tick();
        chk("t3_late_ready2", {31'h0, a_Ready}, 32'd0);

        // 4: slave error zeroes read data
        do_read(32'h0000_4000, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
        do_read(32'h0000_4004, 32'h1234_5678, 1'b1, 32'h0, 1'b1);

        // 5: asynchronous reset during WAIT
        do_read(32'h0000_5000, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0);
        a_Address = 32'h0000_5004;
        a_ReadEnable = 1'b1;
        tick();
        tick();
        chk("t5_busy_wait", {31'h0, a_Busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'h0, a_Busy}, 32'd0);
        chk("t5_ready", {31'h0, a_Ready}, 32'd0);
        chk("t5_rdata", a_MReadData, 32'h0);
        chk("t5_reqvalid", {31'h0, a_bus.Bus_ReqValid}, 32'd0);
        chk("t5_addr", {2'b0, a_bus.Bus_Addr}, 32'h0);
        a_ReadEnable = 1'b0;
        tick();
        rst_n = 1'b1;
        a_bus.Bus_RespValid = 1'b1;
        a_bus.Bus_RData = 32'h7777_7777;
        tick();
        a_bus.Bus_RespValid = 1'b0;
        chk("t5_resp_ignored", {31'h0, a_Ready}, 32'd0);
        chk("t5_rdata_after", a_MReadData, 32'h0);
        tick();
        chk("t5_ready_after", {31'h0, a_Ready}, 32'd0);
        chk("t5_busy_after", {31'h0, a_Busy}, 32'd0);

        // 6: response coincides with timeout hit (TIMEOUT=2)
        b_Address = 32'h0000_6000;
        b_ReadEnable = 1'b1;
        tick();
        b_ReadEnable = 1'b0;
        tick();
        chk("t6_wait0", {31'h0, b_Ready}, 32'd0);
        tick();
        chk("t6_wait1", {31'h0, b_Ready}, 32'd0);
        b_bus.Bus_RespValid = 1'b1;
        b_bus.Bus_RData = 32'h5A5A_5A5A;
        tick();
        b_bus.Bus_RespValid = 1'b0;
        chk("t6_ready", {31'h0, b_Ready}, 32'd1);
        chk("t6_rdata", b_MReadData, 32'h5A5A_5A5A);
        chk("t6_buserr", {31'h0, b_BusErr}, 32'd0);
        tick();

        // 6b: same instance with no response times out after two wait cycles
        b_ReadEnable = 1'b1;
        tick();
        b_ReadEnable = 1'b0;
        tick();
        tick();
        chk("t6b_no_early", {31'h0, b_Ready}, 32'd0);
        tick();
        chk("t6b_ready", {31'h0, b_Ready}, 32'd1);
        chk("t6b_buserr", {31'h0, b_BusErr}, 32'd1);
        chk("t6b_rdata", b_MReadData, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bus bridge directly downstream of the MIPS32 data memory controller.
- Converts the controller's level-held ReadEnable / WriteEnable[3:0] strobes into one registered valid/ready transaction on a variable-latency data bus.
- Returns a one-cycle DataMem_Ready pulse with registered MReadData.
- Adds a response timeout that completes the access with an error flag, so a dead slave cannot hang the pipeline.

Parameters:
- TIMEOUT, 255: cycles to wait in WAIT for Bus_RespValid before forcing an error completion; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  CPU data address.
- MWriteData  in  32  store data from the memory controller.
- WriteEnable  in  4  per-byte write strobes; [3] is bits 31:24.
- ReadEnable  in  1  read request from the memory controller.
- MReadData  out  32  registered read data to the memory controller.
- DataMem_Ready  out  1  one-cycle completion pulse.
- Bus_ReqValid  out  1  request valid.
- Bus_ReqReady  in  1  slave accepts the request.
- Bus_Addr  out  30  word address (Address[31:2]).
- Bus_Write  out  1  1 = write, 0 = read.
- Bus_BE  out  4  byte enables; 4'b1111 on reads.
- Bus_WData  out  32  write data.
- Bus_RespValid  in  1  response valid; one cycle per request.
- Bus_RData  in  32  response read data.
- Bus_Error  in  1  slave error, qualified by Bus_RespValid.
- BusErr  out  1  one-cycle pulse, coincident with DataMem_Ready, on an error completion.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, counter = 0.
  - All outputs 0, including MReadData = 32'h0.
  - An in-flight transaction is abandoned. Any response arriving after reset deasserts is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Launch when ReadEnable = 1 or WriteEnable != 0.
  - Next cycle: enter REQ and register Bus_Addr = Address[31:2], Bus_WData, Bus_BE and Bus_Write.
  - Write: Bus_BE = WriteEnable. Read: Bus_BE = 4'b1111.
  - Read and write together: write wins and the read is dropped. The memory controller never does this.
  - Bus_RespValid in IDLE is discarded (stray or late response).
- REQ:
  - Bus_ReqValid = 1. Addr, WData, BE and Write are held stable until accepted.
  - Bus_ReqValid & Bus_ReqReady: go to WAIT, clear the counter.
  - Bus_RespValid in REQ is ignored. A response is legal only from the cycle after acceptance.
  - No timeout applies in REQ.
- WAIT:
  - Bus_RespValid: go to RESP.
    - Read with Bus_Error = 0: MReadData <= Bus_RData.
    - Read with Bus_Error = 1: MReadData <= 32'h0.
    - Write: MReadData keeps its value.
    - Latch error = Bus_Error.
  - Otherwise, if TIMEOUT != 0 and counter == TIMEOUT-1: go to RESP with error = 1; a read sets MReadData <= 32'h0.
  - Otherwise the counter increments. It saturates and never wraps.
  - If a response and the timeout coincide, the response wins.
- RESP:
  - DataMem_Ready = 1 and BusErr = error, for exactly one cycle; then return to IDLE.
  - ReadEnable / WriteEnable are still high in this cycle (the controller masks them from the next cycle). RESP must not relaunch.
  - The IDLE cycle after RESP may launch a new access.
- Latency:
  - Enable seen at cycle 0 → ReqValid at cycle 1.
  - With immediate ReqReady and response at cycle 2, DataMem_Ready occurs at cycle 3.
  - Minimum is 3 cycles; one access in flight at a time.
- Inputs are sampled only in IDLE. Changes to Address or data during REQ/WAIT have no effect.
- MReadData is stable between read completions.

Decomposition:
- Shared package (dmem_bus_pkg): state encoding constants (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3) and the BE_ALL = 4'b1111 constant.
- One sub-module: dmem_timeout_ctr, a saturating counter with clear, enable and a "hit" output compared against TIMEOUT. It is instantiated once; everything else stays in dmem_bridge.

Test Plan:
1. Read, zero-wait slave:
   - Stimulus: ReadEnable = 1, Address = 32'h0000_1004; ReqReady tied 1; RespValid at cycle 2 with RData = 32'hDEAD_BEEF.
   - Required: Bus_Addr = 30'h401, Bus_BE = 4'b1111, Bus_Write = 0. DataMem_Ready pulses at cycle 3 with MReadData = 32'hDEAD_BEEF; no relaunch while ReadEnable is still high in RESP.
2. Byte write with backpressure:
   - Stimulus: WriteEnable = 4'b0100, MWriteData = 32'h00AB_0000; ReqReady low for 3 cycles.
   - Required: ReqValid and all request fields held stable for 4 cycles. After the ack, DataMem_Ready pulses with BusErr = 0 and MReadData unchanged.
3. Timeout:
   - Stimulus: TIMEOUT = 4; request accepted, no response.
   - Required: DataMem_Ready and BusErr pulse together 5 cycles after acceptance; MReadData = 32'h0.
   - Then a late RespValid arriving in IDLE is ignored, with no second Ready pulse.
4. Slave error:
   - Stimulus: read; RespValid with Bus_Error = 1 and RData = 32'h1234_5678.
   - Required: BusErr = 1, MReadData = 32'h0.
5. Reset mid-operation:
   - Stimulus: reset low during WAIT; a response arrives after release.
   - Required: all outputs 0 immediately (asynchronous), Busy = 0, and the response is discarded.
6. Response and timeout coincide:
   - Stimulus: TIMEOUT = 2; RespValid with RData = 32'h5A5A_5A5A on the cycle the counter hits.
   - Required: MReadData = 32'h5A5A_5A5A, BusErr = 0.
